// File: rtl/rs_pkg.sv
// Shared reservation-station parameters and entry layout, also used by the
// select arbiter and dispatch.
package rs_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int TAG_W      = 6;
  localparam int PAYLOAD_W  = 32;
  localparam int CDB_PORTS  = 2;
  localparam int IDX_W      = $clog2(RS_ENTRIES);
  localparam int CNT_W      = $clog2(RS_ENTRIES) + 1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     src1_tag;
    logic                 src1_rdy;
    logic [TAG_W-1:0]     src2_tag;
    logic                 src2_rdy;
    logic [TAG_W-1:0]     dst_tag;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

  // True when any valid CDB port broadcasts the given tag.
  function automatic logic cdb_hit(input logic [TAG_W-1:0]           tag,
                                   input logic [CDB_PORTS-1:0]       vld,
                                   input logic [CDB_PORTS*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_free_finder.sv
// Lowest-index free-entry priority encoder for the reservation station.
module rs_free_finder
  import rs_pkg::*;
(
  input  logic [RS_ENTRIES-1:0] i_valid,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_any_free
);

  logic [IDX_W-1:0] w_idx;

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    w_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!i_valid[i]) w_idx = IDX_W'(i);
    end
  end

  assign o_idx      = w_idx;
  assign o_any_free = ~&i_valid;

endmodule

// File: rtl/rs_wakeup.sv
// Reservation-station entry array: CDB tag snooping, request generation for the
// select arbiter, and the registered issue packet for the granted entry.
module rs_wakeup
  import rs_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [TAG_W-1:0]           alloc_src1_tag,
  input  logic                       alloc_src1_rdy,
  input  logic [TAG_W-1:0]           alloc_src2_tag,
  input  logic                       alloc_src2_rdy,
  input  logic [TAG_W-1:0]           alloc_dst_tag,
  input  logic [PAYLOAD_W-1:0]       alloc_payload,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  output logic [RS_ENTRIES-1:0]      reqs,
  input  logic [IDX_W-1:0]           grant,
  input  logic                       grant_valid,
  output logic                       issue_valid,
  output logic [TAG_W-1:0]           issue_dst_tag,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  output logic [CNT_W-1:0]           occupancy
);

  logic [RS_ENTRIES-1:0] w_valid;
  logic [RS_ENTRIES-1:0] w_reqs;
  logic [TAG_W-1:0]      w_dst     [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  w_pay     [RS_ENTRIES];
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_any_free;
  logic                  w_alloc;
  logic                  w_issue;
  logic                  w_byp1;
  logic                  w_byp2;
  logic [CNT_W-1:0]      w_occ;

  logic                  r_issue_valid;
  logic [TAG_W-1:0]      r_issue_dst_tag;
  logic [PAYLOAD_W-1:0]  r_issue_payload;

  rs_free_finder u_free_finder (
    .i_valid    (w_valid),
    .o_idx      (w_free_idx),
    .o_any_free (w_any_free)
  );

  assign w_alloc = alloc_valid && w_any_free && !flush;
  assign w_issue = grant_valid && w_reqs[grant] && !flush;
  assign w_byp1  = cdb_hit(alloc_src1_tag, cdb_valid, cdb_tag);
  assign w_byp2  = cdb_hit(alloc_src2_tag, cdb_valid, cdb_tag);

  for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_entry
    rs_entry_t r_ent;
    logic      w_hit1;
    logic      w_hit2;
    logic      w_alloc_here;
    logic      w_grant_here;

    assign w_hit1       = cdb_hit(r_ent.src1_tag, cdb_valid, cdb_tag);
    assign w_hit2       = cdb_hit(r_ent.src2_tag, cdb_valid, cdb_tag);
    assign w_alloc_here = w_alloc && (w_free_idx == IDX_W'(i));
    assign w_grant_here = w_issue && (grant == IDX_W'(i));

    // Alloc only targets a free entry and grant only a valid one, so the
    // two branches below never compete for the same entry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ent <= '0;
      end else if (flush) begin
        r_ent.valid <= 1'b0;
      end else if (w_alloc_here) begin
        r_ent.valid    <= 1'b1;
        r_ent.src1_tag <= alloc_src1_tag;
        r_ent.src1_rdy <= alloc_src1_rdy | w_byp1;
        r_ent.src2_tag <= alloc_src2_tag;
        r_ent.src2_rdy <= alloc_src2_rdy | w_byp2;
        r_ent.dst_tag  <= alloc_dst_tag;
        r_ent.payload  <= alloc_payload;
      end else if (r_ent.valid) begin
        if (w_grant_here) r_ent.valid <= 1'b0;
        if (w_hit1) r_ent.src1_rdy <= 1'b1;
        if (w_hit2) r_ent.src2_rdy <= 1'b1;
      end
    end

    assign w_valid[i] = r_ent.valid;
    assign w_reqs[i]  = r_ent.valid & r_ent.src1_rdy & r_ent.src2_rdy;
    assign w_dst[i]   = r_ent.dst_tag;
    assign w_pay[i]   = r_ent.payload;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid   <= 1'b0;
      r_issue_dst_tag <= '0;
      r_issue_payload <= '0;
    end else if (w_issue) begin
      r_issue_valid   <= 1'b1;
      r_issue_dst_tag <= w_dst[grant];
      r_issue_payload <= w_pay[grant];
    end else begin
      r_issue_valid   <= 1'b0;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < RS_ENTRIES; i++) w_occ = w_occ + CNT_W'(w_valid[i]);
  end

  // A grant to a non-requesting entry is dropped; flag it so the arbiter bug is visible.
  a_grant_legal: assert property (@(posedge clk) disable iff (!rst)
                                  (grant_valid && !flush) |-> w_reqs[grant])
    else $warning("rs_wakeup: grant to non-requesting entry %0d ignored", grant);

  assign alloc_ready   = w_any_free;
  assign reqs          = w_reqs;
  assign occupancy     = w_occ;
  assign issue_valid   = r_issue_valid;
  assign issue_dst_tag = r_issue_dst_tag;
  assign issue_payload = r_issue_payload;

endmodule

// File: tb/tb_rs_wakeup.sv
// Directed self-checking bench for rs_wakeup: reset, issue path, CDB wakeup,
// allocation bypass, full/refill, simultaneous alloc+grant, flush, illegal grant.
module tb_rs_wakeup;
  import rs_pkg::*;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_src1_tag;
  logic                       alloc_src1_rdy;
  logic [TAG_W-1:0]           alloc_src2_tag;
  logic                       alloc_src2_rdy;
  logic [TAG_W-1:0]           alloc_dst_tag;
  logic [PAYLOAD_W-1:0]       alloc_payload;
  logic [CDB_PORTS-1:0]       cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
  logic [RS_ENTRIES-1:0]      reqs;
  logic [IDX_W-1:0]           grant;
  logic                       grant_valid;
  logic                       issue_valid;
  logic [TAG_W-1:0]           issue_dst_tag;
  logic [PAYLOAD_W-1:0]       issue_payload;
  logic [CNT_W-1:0]           occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  rs_wakeup dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_src1_tag (alloc_src1_tag),
    .alloc_src1_rdy (alloc_src1_rdy),
    .alloc_src2_tag (alloc_src2_tag),
    .alloc_src2_rdy (alloc_src2_rdy),
    .alloc_dst_tag  (alloc_dst_tag),
    .alloc_payload  (alloc_payload),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .reqs           (reqs),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .issue_valid    (issue_valid),
    .issue_dst_tag  (issue_dst_tag),
    .issue_payload  (issue_payload),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    grant_valid = 1'b0;
    grant       = '0;
  endtask

  task automatic set_alloc(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                           input logic r2, input logic [5:0] dst, input logic [31:0] pay);
    alloc_valid    = 1'b1;
    alloc_src1_tag = s1;
    alloc_src1_rdy = r1;
    alloc_src2_tag = s2;
    alloc_src2_rdy = r2;
    alloc_dst_tag  = dst;
    alloc_payload  = pay;
  endtask

  task automatic do_grant(input logic [2:0] g);
    grant_valid = 1'b1;
    grant       = g;
  endtask

  initial begin
    idle();
    set_alloc(6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0);
    alloc_valid = 1'b0;
    rst = 1'b0;
    #12;
    chk("reset_reqs", 64'(reqs), 64'h0);
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_issue_payload", 64'(issue_payload), 64'd0);
    chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Ready uop into empty RS, then grant it.
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd7, 32'hA5A5_0001);
    step();
    idle();
    chk("t1_reqs", 64'(reqs), 64'h01);
    chk("t1_occ", 64'(occupancy), 64'd1);
    do_grant(3'd0);
    step();
    idle();
    chk("t1_issue_valid", 64'(issue_valid), 64'd1);
    chk("t1_issue_payload", 64'(issue_payload), 64'hA5A5_0001);
    chk("t1_issue_dst", 64'(issue_dst_tag), 64'd7);
    chk("t1_occ_after", 64'(occupancy), 64'd0);
    step();
    chk("t1_issue_drop", 64'(issue_valid), 64'd0);

    // Src1 tag 5 woken by CDB port 1.
    set_alloc(6'd5, 1'b0, 6'd6, 1'b1, 6'd8, 32'h0000_0002);
    step();
    idle();
    chk("t2_not_ready", 64'(reqs), 64'h00);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd5, 6'd3};
    step();
    idle();
    chk("t2_invalid_port_no_wake", 64'(reqs), 64'h00);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd5, 6'd0};
    chk("t2_no_same_cycle_req", 64'(reqs), 64'h00);
    step();
    idle();
    chk("t2_wake_req", 64'(reqs), 64'h01);
    do_grant(3'd0);
    step();
    idle();
    chk("t2_issue_dst", 64'(issue_dst_tag), 64'd8);

    // Allocation bypass on src2 tag 9.
    set_alloc(6'd1, 1'b1, 6'd9, 1'b0, 6'd10, 32'h0000_0003);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd9};
    step();
    idle();
    chk("t3_bypass_req", 64'(reqs), 64'h01);
    do_grant(3'd0);
    step();
    idle();
    chk("t3_issue_payload", 64'(issue_payload), 64'h0000_0003);

    // Both sources wake in the same cycle from different ports.
    set_alloc(6'd12, 1'b0, 6'd13, 1'b0, 6'd11, 32'h0000_0004);
    step();
    idle();
    cdb_valid = 2'b11;
    cdb_tag   = {6'd13, 6'd12};
    step();
    idle();
    chk("t4_dual_wake", 64'(reqs), 64'h01);
    do_grant(3'd0);
    step();
    idle();
    chk("t4_occ", 64'(occupancy), 64'd0);

    // Fill all 8 entries.
    for (int i = 0; i < RS_ENTRIES; i++) begin
      set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'(i), 32'd100 + 32'(i));
      step();
    end
    chk("t5_full_ready", 64'(alloc_ready), 64'd0);
    chk("t5_full_occ", 64'(occupancy), 64'd8);
    chk("t5_full_reqs", 64'(reqs), 64'hFF);
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd40, 32'h0000_BEEF);
    do_grant(3'd3);
    step();
    grant_valid = 1'b0;
    chk("t5_grant3_payload", 64'(issue_payload), 64'd103);
    chk("t5_grant3_dst", 64'(issue_dst_tag), 64'd3);
    chk("t5_no_refill_in_grant", 64'(occupancy), 64'd7);
    chk("t5_reqs_hole", 64'(reqs), 64'hF7);
    step();
    alloc_valid = 1'b0;
    chk("t5_refilled_occ", 64'(occupancy), 64'd8);
    chk("t5_refilled_ready", 64'(alloc_ready), 64'd0);
    do_grant(3'd3);
    step();
    idle();
    chk("t5_refill_payload", 64'(issue_payload), 64'h0000_BEEF);
    chk("t5_refill_dst", 64'(issue_dst_tag), 64'd40);

    // Simultaneous alloc (into entry 3) and grant of entry 5.
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd41, 32'h0000_C0DE);
    do_grant(3'd5);
    step();
    idle();
    chk("t6_both_occ", 64'(occupancy), 64'd7);
    chk("t6_both_reqs", 64'(reqs), 64'hDF);
    chk("t6_both_payload", 64'(issue_payload), 64'd105);

    // Flush concurrent with alloc and grant.
    flush = 1'b1;
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd42, 32'h0000_0042);
    do_grant(3'd0);
    step();
    idle();
    chk("t7_flush_occ", 64'(occupancy), 64'd0);
    chk("t7_flush_issue", 64'(issue_valid), 64'd0);
    chk("t7_flush_reqs", 64'(reqs), 64'h00);
    step();
    chk("t7_flush_no_write", 64'(occupancy), 64'd0);

    // Illegal grants: idle entry, then valid but not-ready entry.
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 32'h0000_0050);
    step();
    set_alloc(6'd20, 1'b0, 6'd2, 1'b1, 6'd51, 32'h0000_0051);
    step();
    idle();
    do_grant(3'd4);
    step();
    idle();
    chk("t8_idle_grant_issue", 64'(issue_valid), 64'd0);
    chk("t8_idle_grant_occ", 64'(occupancy), 64'd2);
    do_grant(3'd1);
    step();
    idle();
    chk("t8_notready_grant_issue", 64'(issue_valid), 64'd0);
    chk("t8_notready_grant_reqs", 64'(reqs), 64'h01);

    // Mid-run async reset with 3 valid entries and an issue in flight.
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd52, 32'h0000_0052);
    step();
    set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 6'd53, 32'h0000_0053);
    step();
    idle();
    do_grant(3'd0);
    step();
    idle();
    chk("t9_pre_occ", 64'(occupancy), 64'd3);
    chk("t9_pre_issue", 64'(issue_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t9_rst_reqs", 64'(reqs), 64'h00);
    chk("t9_rst_occ", 64'(occupancy), 64'd0);
    chk("t9_rst_issue", 64'(issue_valid), 64'd0);
    chk("t9_rst_ready", 64'(alloc_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
